// File: rtl/deserializer_with_counter_pkg.sv
// Shared types for the burst deserializer.
package deserializer_with_counter_pkg;

  // Two-state control: waiting for a start request, or capturing serial bits.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage : deserializer_with_counter_pkg

// File: rtl/deserializer_with_counter_mod_counter.sv
// Modulo-N up-counter with synchronous reset, synchronous clear, count enable
// and a terminal-count flag that is high while the count sits at MODULUS-1.
module mod_counter #(
  parameter int MODULUS = 8,
  parameter int WIDTH   = (MODULUS > 1) ? $clog2(MODULUS) : 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_count;

  // Count enabled events, wrapping to zero after the terminal value.
  always_ff @(posedge i_clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (i_rst || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= (r_count == LAST) ? '0 : r_count + WIDTH'(1);
    end
  end

  assign o_tc = (r_count == LAST);

endmodule : mod_counter

// File: rtl/deserializer_with_counter.sv
// Serial-to-parallel converter for a fixed-length burst. After a start
// request it samples DATA_LENGTH bits MSB-first, one per clock, and presents
// every WORD_SIZE bits as a registered word with a one-cycle RCO strobe.
module deserializer_with_counter
  import deserializer_with_counter_pkg::*;
#(
  parameter int DATA_LENGTH = 16,
  parameter int WORD_SIZE   = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 data_in,
  output logic [WORD_SIZE-1:0] data_out,
  output logic                 busy,
  output logic                 RCO
);

  localparam int WORDS = DATA_LENGTH / WORD_SIZE;

  // Reject burst lengths that do not split into whole words.
  if ((DATA_LENGTH == 0) || (WORD_SIZE < 2) || ((DATA_LENGTH % WORD_SIZE) != 0)) begin : g_bad_params
    $error("deserializer_with_counter: DATA_LENGTH must be a nonzero multiple of WORD_SIZE (>= 2)");
  end

  state_t               r_state;
  logic                 r_busy;
  logic                 r_rco;
  logic [WORD_SIZE-1:0] r_data_out;
  // Only the low WORD_SIZE-1 bits of the shift register are ever read back:
  // the oldest bit leaves the register in the same edge that completes a word.
  logic [WORD_SIZE-2:0] r_shreg;

  logic                 w_shifting;
  logic                 w_start_accept;
  logic                 w_bit_tc;
  logic                 w_word_tc;
  logic                 w_word_done;
  logic                 w_burst_done;
  logic [WORD_SIZE-1:0] w_next_word;

  assign w_shifting     = (r_state == ST_SHIFT);
  assign w_start_accept = (r_state == ST_IDLE) && start;
  assign w_word_done    = w_shifting && w_bit_tc;
  assign w_burst_done   = w_word_done && w_word_tc;
  assign w_next_word    = {r_shreg, data_in};

  // Bit position inside the current word; terminal count marks its last bit.
  mod_counter #(
    .MODULUS (WORD_SIZE),
    .WIDTH   ($clog2(WORD_SIZE))
  ) u_bit_cnt (
    .i_clk (clock),
    .i_rst (reset),
    .i_clr (w_start_accept),
    .i_en  (w_shifting),
    .o_tc  (w_bit_tc)
  );

  // Word index inside the burst; terminal count marks the final word.
  mod_counter #(
    .MODULUS (WORDS),
    .WIDTH   ($clog2(WORDS) + 1)
  ) u_word_cnt (
    .i_clk (clock),
    .i_rst (reset),
    .i_clr (w_start_accept),
    .i_en  (w_word_done),
    .o_tc  (w_word_tc)
  );

  // Control FSM with the shift register and all registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_rco      <= 1'b0;
      r_data_out <= '0;
      r_shreg    <= '0;
    end else begin
      r_rco <= w_word_done;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_SHIFT;
            r_busy  <= 1'b1;
          end
        end
        ST_SHIFT: begin
          r_shreg <= w_next_word[WORD_SIZE-2:0];
          if (w_word_done) begin
            r_data_out <= w_next_word;
          end
          if (w_burst_done) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out = r_data_out;
  assign busy     = r_busy;
  assign RCO      = r_rco;

endmodule : deserializer_with_counter

// File: tb/tb_deserializer_with_counter.sv
// Directed bench for deserializer_with_counter: default 16/8 instance plus
// 24/8 and 8/8 instances for the parameter sweep.
module tb_deserializer_with_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_v [3];
  logic       din_v   [3];
  logic [7:0] dout_v  [3];
  logic       busy_v  [3];
  logic       rco_v   [3];

  logic [7:0] exp_dout [3];
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  deserializer_with_counter #(.DATA_LENGTH(16), .WORD_SIZE(8)) dut0 (
    .clock(clk), .reset(reset), .start(start_v[0]), .data_in(din_v[0]),
    .data_out(dout_v[0]), .busy(busy_v[0]), .RCO(rco_v[0])
  );

  deserializer_with_counter #(.DATA_LENGTH(24), .WORD_SIZE(8)) dut1 (
    .clock(clk), .reset(reset), .start(start_v[1]), .data_in(din_v[1]),
    .data_out(dout_v[1]), .busy(busy_v[1]), .RCO(rco_v[1])
  );

  deserializer_with_counter #(.DATA_LENGTH(8), .WORD_SIZE(8)) dut2 (
    .clock(clk), .reset(reset), .start(start_v[2]), .data_in(din_v[2]),
    .data_out(dout_v[2]), .busy(busy_v[2]), .RCO(rco_v[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full burst on instance d; optionally re-pulses start at bit 5.
  task automatic burst(input int d, input int nbits, input logic [23:0] bits, input bit poke_start);
    int   rco_cnt;
    logic exp_rco;
    rco_cnt    = 0;
    start_v[d] = 1'b1;
    din_v[d]   = 1'b0;
    tick();
    start_v[d] = 1'b0;
    check($sformatf("d%0d start busy", d), 32'(busy_v[d]), 32'd1);
    check($sformatf("d%0d start rco", d), 32'(rco_v[d]), 32'd0);
    for (int k = 1; k <= nbits; k++) begin
      din_v[d]   = bits[nbits-k];
      start_v[d] = poke_start && (k == 5);
      tick();
      exp_rco = ((k % 8) == 0);
      if (exp_rco) exp_dout[d] = bits[nbits-k +: 8];
      check($sformatf("d%0d bit%0d busy", d, k), 32'(busy_v[d]), 32'(k != nbits));
      check($sformatf("d%0d bit%0d rco", d, k), 32'(rco_v[d]), 32'(exp_rco));
      check($sformatf("d%0d bit%0d dout", d, k), 32'(dout_v[d]), 32'(exp_dout[d]));
      if (rco_v[d] === 1'b1) rco_cnt++;
    end
    start_v[d] = 1'b0;
    check($sformatf("d%0d rco count", d), 32'(rco_cnt), 32'(nbits / 8));
  endtask

  // One quiet cycle: must stay idle with data_out held.
  task automatic idle_check(input int d);
    tick();
    check($sformatf("d%0d idle busy", d), 32'(busy_v[d]), 32'd0);
    check($sformatf("d%0d idle rco", d), 32'(rco_v[d]), 32'd0);
    check($sformatf("d%0d idle dout", d), 32'(dout_v[d]), 32'(exp_dout[d]));
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      start_v[i]  = 1'b1;
      din_v[i]    = 1'b0;
      exp_dout[i] = 8'h00;
    end

    // Reset with start held: reset wins, nothing starts.
    reset = 1'b1;
    tick();
    check("rst busy", 32'(busy_v[0]), 32'd0);
    check("rst rco", 32'(rco_v[0]), 32'd0);
    check("rst dout", 32'(dout_v[0]), 32'h00);
    check("rst dout d1", 32'(dout_v[1]), 32'h00);
    check("rst dout d2", 32'(dout_v[2]), 32'h00);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
    idle_check(0);

    // Basic burst: D1 then 46.
    burst(0, 16, 24'h00D146, 1'b0);
    check("basic last word", 32'(dout_v[0]), 32'h46);
    idle_check(0);
    idle_check(0);

    // start re-pulsed mid-burst is ignored.
    burst(0, 16, 24'h00D146, 1'b1);
    idle_check(0);

    // Reset after the 4th bit aborts the burst.
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      din_v[0] = k[0];
      tick();
      check("abort busy", 32'(busy_v[0]), 32'd1);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) exp_dout[i] = 8'h00;
    check("abort rst busy", 32'(busy_v[0]), 32'd0);
    check("abort rst rco", 32'(rco_v[0]), 32'd0);
    check("abort rst dout", 32'(dout_v[0]), 32'h00);
    idle_check(0);
    burst(0, 16, 24'h00A53C, 1'b0);
    check("after abort word", 32'(dout_v[0]), 32'h3C);
    idle_check(0);

    // Back-to-back bursts: start on the edge right after busy falls.
    burst(0, 16, 24'h00FFFF, 1'b0);
    check("b2b ones", 32'(dout_v[0]), 32'hFF);
    burst(0, 16, 24'h000000, 1'b0);
    check("b2b zeros", 32'(dout_v[0]), 32'h00);
    idle_check(0);

    // Parameter sweep: 24/8 gives three words, 8/8 a single word.
    burst(1, 24, 24'h5AC381, 1'b0);
    idle_check(1);
    burst(2, 8, 24'h000096, 1'b0);
    check("d2 word", 32'(dout_v[2]), 32'h96);
    idle_check(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_deserializer_with_counter
